lights_controller: RTL and testbench

LIGHTS_CONTROLLER -- requirements
Module: lights_controller

---
 rtl/lights_controller_pkg.sv | 26 ++
 rtl/lights_dimmer.sv | 67 ++++++
 rtl/lights_controller.sv | 168 ++++++++++++++++
 tb/tb_lights_controller.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/lights_controller_pkg.sv
// ---------------------------------------------------------------------------
// lights_controller_pkg
// Shared constants for the lighting controller: sensor widths, the daylight
// threshold and the FSM state encoding. Every file of the controller imports
// this package.
// ---------------------------------------------------------------------------
package lights_controller_pkg;

    // Sensor data widths
    localparam int DAYLIGHT_W = 8;
    localparam int MOTION_W   = 4;

    // Ambient level below which the room counts as dark
    localparam logic [DAYLIGHT_W-1:0] LIGHT_THRESHOLD = 8'd100;

    // FSM state codes; codes 6 and 7 are unused and recover to OFF
    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_ON        = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RAMP_DOWN = 3'd4,
        ST_MANUAL    = 3'd5
    } state_t;

endpackage

// File: rtl/lights_dimmer.sv
// ---------------------------------------------------------------------------
// lights_dimmer
// Saturating 8-bit brightness register.
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_up          : add RAMP_STEP, saturating at 255
//   i_down        : subtract RAMP_STEP, saturating at 0
//   i_set_max     : load 255
//   i_hold        : freeze the level (overrides every other control)
//   o_level       : registered brightness
//   o_lit         : registered, high iff o_level != 0
// ---------------------------------------------------------------------------
module lights_dimmer
    import lights_controller_pkg::*;
#(
    parameter int RAMP_STEP = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_set_max,
    input  logic       i_hold,
    output logic [7:0] o_level,
    output logic       o_lit
);

    localparam logic [7:0] STEP8 = 8'(RAMP_STEP);

    logic [7:0] r_level;
    logic       r_lit;
    logic [8:0] w_sum;
    logic [7:0] w_up_level;
    logic [7:0] w_dn_level;
    logic [7:0] w_next;

    // Sum is one bit wider so the carry shows saturation
    assign w_sum      = {1'b0, r_level} + {1'b0, STEP8};
    assign w_up_level = w_sum[8] ? 8'hFF : w_sum[7:0];
    assign w_dn_level = (r_level > STEP8) ? (r_level - STEP8) : 8'd0;

    always_comb begin
        w_next = r_level;
        if (i_hold)
            w_next = r_level;
        else if (i_set_max)
            w_next = 8'hFF;
        else if (i_up)
            w_next = w_up_level;
        else if (i_down)
            w_next = w_dn_level;
    end

    // lit is derived from the next level so it tracks brightness exactly
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_level <= 8'd0;
            r_lit   <= 1'b0;
        end else begin
            r_level <= w_next;
            r_lit   <= (w_next != 8'd0);
        end
    end

    assign o_level = r_level;
    assign o_lit   = r_lit;

endmodule

// File: rtl/lights_controller.sv
// ---------------------------------------------------------------------------
// lights_controller
// Occupancy- and daylight-driven dimmer controller with hold-off timer and
// manual override.
//   clk           : single clock, rising edge
//   reset         : asynchronous active-high reset
//   daylight      : ambient light level
//   presence      : motion sensor data, nonzero = occupied
//   tick          : single-cycle timebase strobe
//   manual_toggle : single-cycle manual override toggle request
//   brightness    : registered dimmer level 0..255
//   lights        : registered, high iff brightness != 0
//   state         : registered FSM state code
// ---------------------------------------------------------------------------
module lights_controller
    import lights_controller_pkg::*;
#(
    parameter int HOLD_TICKS = 30,
    parameter int RAMP_STEP  = 16,
    parameter int HYST       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DAYLIGHT_W-1:0] daylight,
    input  logic [MOTION_W-1:0]   presence,
    input  logic                  tick,
    input  logic                  manual_toggle,
    output logic [7:0]            brightness,
    output logic                  lights,
    output logic [2:0]            state
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_TICKS);
    localparam logic [DAYLIGHT_W:0] BRIGHT_LEVEL =
        {1'b0, LIGHT_THRESHOLD} + (DAYLIGHT_W+1)'(HYST);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_dark_q;
    logic [7:0] r_hold_cnt;

    logic       w_occupied;
    logic       w_up;
    logic       w_down;
    logic       w_set_max;
    logic       w_hold;
    logic       w_hold_dec;
    logic       w_hold_load;
    logic [7:0] w_level;
    logic       w_lit;

    assign w_occupied = (presence != '0);

    // Daylight with hysteresis: set below threshold, clear at threshold+HYST
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_dark_q <= 1'b0;
        else if (daylight < LIGHT_THRESHOLD)
            r_dark_q <= 1'b1;
        else if ({1'b0, daylight} >= BRIGHT_LEVEL)
            r_dark_q <= 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_OFF;
        else
            r_state <= w_state_nxt;
    end

    // Next state and dimmer controls. A tick applies the current state's
    // action even when a transition happens, except for a manual toggle.
    always_comb begin
        w_state_nxt = r_state;
        w_up        = 1'b0;
        w_down      = 1'b0;
        w_set_max   = 1'b0;
        w_hold      = 1'b0;
        w_hold_dec  = 1'b0;
        if (manual_toggle) begin
            if (r_state == ST_MANUAL) begin
                w_state_nxt = ST_RAMP_DOWN;
                w_hold      = 1'b1;
            end else begin
                w_state_nxt = ST_MANUAL;
                w_set_max   = 1'b1;
            end
        end else begin
            case (r_state)
                ST_OFF: begin
                    if (w_occupied && r_dark_q)
                        w_state_nxt = ST_RAMP_UP;
                end
                ST_RAMP_UP: begin
                    w_up = tick;
                    if (w_level == 8'hFF)
                        w_state_nxt = ST_ON;
                    else if (!r_dark_q)
                        w_state_nxt = ST_RAMP_DOWN;
                    else if (!w_occupied)
                        w_state_nxt = ST_HOLD;
                end
                ST_ON: begin
                    if (!r_dark_q)
                        w_state_nxt = ST_RAMP_DOWN;
                    else if (!w_occupied)
                        w_state_nxt = ST_HOLD;
                end
                ST_HOLD: begin
                    w_hold = 1'b1;
                    if (w_occupied && r_dark_q)
                        w_state_nxt = ST_RAMP_UP;
                    else if (!r_dark_q)
                        w_state_nxt = ST_RAMP_DOWN;
                    else if (tick) begin
                        // A count of 0 can only be seen after a glitch; treat as expired
                        if (r_hold_cnt <= 8'd1)
                            w_state_nxt = ST_RAMP_DOWN;
                        else
                            w_hold_dec = 1'b1;
                    end
                end
                ST_RAMP_DOWN: begin
                    w_down = tick;
                    if (w_level == 8'd0)
                        w_state_nxt = ST_OFF;
                    else if (w_occupied && r_dark_q)
                        w_state_nxt = ST_RAMP_UP;
                end
                ST_MANUAL: begin
                    w_hold = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_OFF;
                end
            endcase
        end
    end

    assign w_hold_load = (w_state_nxt == ST_HOLD) && (r_state != ST_HOLD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_hold_cnt <= 8'd0;
        else if (w_hold_load)
            r_hold_cnt <= HOLD_LOAD;
        else if (w_hold_dec)
            r_hold_cnt <= r_hold_cnt - 8'd1;
    end

    lights_dimmer #(
        .RAMP_STEP (RAMP_STEP)
    ) u_dimmer (
        .i_clk     (clk),
        .i_rst     (reset),
        .i_up      (w_up),
        .i_down    (w_down),
        .i_set_max (w_set_max),
        .i_hold    (w_hold),
        .o_level   (w_level),
        .o_lit     (w_lit)
    );

    assign brightness = w_level;
    assign lights     = w_lit;
    assign state      = r_state;

endmodule

// File: tb/tb_lights_controller.sv
// ---------------------------------------------------------------------------
// tb_lights_controller
// Directed bench for lights_controller with default parameters.
// ---------------------------------------------------------------------------
module tb_lights_controller;
    import lights_controller_pkg::*;

    logic                  clk;
    logic                  rst;
    logic [DAYLIGHT_W-1:0] daylight;
    logic [MOTION_W-1:0]   presence;
    logic                  tick;
    logic                  manual_toggle;
    logic [7:0]            brightness;
    logic                  lights;
    logic [2:0]            state;

    int n_cmp;
    int n_mis;

    lights_controller dut (
        .clk           (clk),
        .reset         (rst),
        .daylight      (daylight),
        .presence      (presence),
        .tick          (tick),
        .manual_toggle (manual_toggle),
        .brightness    (brightness),
        .lights        (lights),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic chk_all(input string tag, input int st, input int br);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".bright"}, 32'(brightness), 32'(br));
        chk({tag, ".lights"}, 32'(lights), (br != 0) ? 32'd1 : 32'd0);
    endtask

    localparam logic [7:0] DARK = LIGHT_THRESHOLD - 8'd1;

    initial begin
        int exp_b;
        n_cmp = 0;
        n_mis = 0;
        rst = 1'b1;
        daylight = DARK;
        presence = '0;
        tick = 1'b0;
        manual_toggle = 1'b0;

        // Reset state
        step();
        step();
        chk_all("reset", 0, 0);
        rst = 1'b0;

        // dark_q sets on the first edge; presence then starts the ramp
        step();
        chk_all("idle", 0, 0);
        presence = 4'd1;
        step();
        chk_all("to_ramp_up", 1, 0);

        // 16 ticks: 16, 32 ... 240, then saturate at 255
        for (int i = 1; i <= 16; i++) begin
            pulse_tick();
            exp_b = (16 * i > 255) ? 255 : 16 * i;
            chk_all($sformatf("ramp_up%0d", i), 1, exp_b);
        end
        step();
        chk_all("on", 2, 255);
        step();
        chk_all("on_stay", 2, 255);

        // Vacancy: hold for 30 ticks, then ramp down
        presence = '0;
        step();
        chk_all("hold_entry", 3, 255);
        for (int i = 1; i <= 29; i++) pulse_tick();
        chk_all("hold29", 3, 255);
        pulse_tick();
        chk_all("hold_expire", 4, 255);
        pulse_tick();
        chk_all("ramp_dn1", 4, 239);
        for (int i = 2; i <= 15; i++) pulse_tick();
        chk_all("ramp_dn15", 4, 15);
        pulse_tick();
        chk_all("ramp_dn16", 4, 0);
        step();
        chk_all("off_again", 0, 0);

        // Hysteresis
        presence = 4'd1;
        step();
        chk_all("hy_ramp_up", 1, 0);
        for (int i = 0; i < 3; i++) pulse_tick();
        chk_all("hy_48", 1, 48);
        daylight = LIGHT_THRESHOLD + 8'd4;
        step();
        step();
        chk_all("hy_plus4", 1, 48);
        daylight = LIGHT_THRESHOLD + 8'd8;
        step();
        chk("hy_dark_edge.state", 32'(state), 32'd1);
        step();
        chk_all("hy_plus8", 4, 48);

        // Hold interrupted by presence with 5 ticks remaining
        daylight = DARK;
        step();
        chk_all("redark_wait", 4, 48);
        step();
        chk_all("redark_ramp_up", 1, 48);
        presence = '0;
        step();
        chk_all("hold2_entry", 3, 48);
        for (int i = 0; i < 25; i++) pulse_tick();
        chk_all("hold2_cnt5", 3, 48);
        presence = 4'd1;
        step();
        chk_all("hold2_resume", 1, 48);

        // Climb to 128 then reset asynchronously between edges
        for (int i = 0; i < 5; i++) pulse_tick();
        chk_all("mid_ramp_128", 1, 128);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_reset", 0, 0);
        #1;
        rst = 1'b0;
        step();
        chk_all("post_reset", 0, 0);

        // Manual override with bright daylight
        daylight = LIGHT_THRESHOLD + 8'd20;
        presence = '0;
        step();
        step();
        chk_all("bright_off", 0, 0);
        manual_toggle = 1'b1;
        step();
        manual_toggle = 1'b0;
        chk_all("manual", 5, 255);
        daylight = DARK;
        presence = 4'd1;
        step();
        step();
        pulse_tick();
        chk_all("manual_ignore", 5, 255);
        manual_toggle = 1'b1;
        tick = 1'b1;
        step();
        manual_toggle = 1'b0;
        tick = 1'b0;
        chk_all("manual_exit", 4, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
